// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-requester arbiter and sequencer for a shared single-port
//               memory. Runs a two-cycle read (address phase, then
//               output-enable phase) and a one-cycle write. The ACK cycle
//               doubles as an arbitration slot for back-to-back accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int PRIO_FIXED = 0,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ce,
    output logic              mem_r,
    output logic              mem_oe,
    output logic              mem_w
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD_A = 3'd1;
    localparam logic [2:0] c_ST_RD_D = 3'd2;
    localparam logic [2:0] c_ST_WR   = 3'd3;
    localparam logic [2:0] c_ST_ACK  = 3'd4;

    localparam logic c_FIXED = (PRIO_FIXED != 0);

    // Sequencer state and transaction bookkeeping
    logic [2:0]        r_state;
    logic              r_owner;       // requester that owns the current access
    logic              r_last_grant;  // most recent winner, for round-robin

    // Registered outputs
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_busy;
    logic              r_mem_ce;
    logic              r_mem_r;
    logic              r_mem_oe;
    logic              r_mem_w;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;

    // Arbitration results
    logic              w_in_ack;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_lock_hold;
    logic              w_win_valid;
    logic              w_winner;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    // Next-cycle values
    logic [2:0]        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_last_grant_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_gnt0_nxt;
    logic              w_gnt1_nxt;
    logic              w_ack0_nxt;
    logic              w_ack1_nxt;
    logic              w_busy_nxt;
    logic              w_ce_nxt;
    logic              w_r_nxt;
    logic              w_oe_nxt;
    logic              w_w_nxt;

    // Pick a winner; the just-acked requester only competes again when it holds lock
    always_comb begin
        w_in_ack    = (r_state == c_ST_ACK);
        w_elig0     = req0 && !(w_in_ack && !r_owner && !lock0);
        w_elig1     = req1 && !(w_in_ack &&  r_owner && !lock1);
        w_lock_hold = w_in_ack && (r_owner ? (req1 && lock1) : (req0 && lock0));
        w_win_valid = w_elig0 || w_elig1;

        if (w_lock_hold) begin
            w_winner = r_owner;
        end else if (w_elig0 && w_elig1) begin
            w_winner = c_FIXED ? 1'b0 : ~r_last_grant;
        end else begin
            w_winner = w_elig1;
        end

        w_win_we    = w_winner ? we1    : we0;
        w_win_addr  = w_winner ? addr1  : addr0;
        w_win_wdata = w_winner ? wdata1 : wdata0;
    end

    // Next state, latched transaction and next registered outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_rdata_nxt      = r_rdata;

        case (r_state)
            c_ST_IDLE, c_ST_ACK: begin
                if (w_win_valid) begin
                    w_owner_nxt      = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_mem_addr_nxt   = w_win_addr;
                    w_mem_wdata_nxt  = w_win_wdata;
                    w_state_nxt      = w_win_we ? c_ST_WR : c_ST_RD_A;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_A: w_state_nxt = c_ST_RD_D;
            c_ST_RD_D: begin
                // Memory drives valid data during the output-enable phase
                w_rdata_nxt = mem_rdata;
                w_state_nxt = c_ST_ACK;
            end
            c_ST_WR:   w_state_nxt = c_ST_ACK;
            default:   w_state_nxt = c_ST_IDLE;
        endcase

        // Outputs for the coming cycle are a pure decode of the next state
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_gnt0_nxt = w_busy_nxt && !w_owner_nxt;
        w_gnt1_nxt = w_busy_nxt &&  w_owner_nxt;
        w_ack0_nxt = (w_state_nxt == c_ST_ACK) && !w_owner_nxt;
        w_ack1_nxt = (w_state_nxt == c_ST_ACK) &&  w_owner_nxt;
        w_r_nxt    = (w_state_nxt == c_ST_RD_A);
        w_oe_nxt   = (w_state_nxt == c_ST_RD_D);
        w_w_nxt    = (w_state_nxt == c_ST_WR);
        w_ce_nxt   = w_r_nxt || w_oe_nxt || w_w_nxt;
    end

    // State register and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_ce     <= 1'b0;
            r_mem_r      <= 1'b0;
            r_mem_oe     <= 1'b0;
            r_mem_w      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gnt0       <= w_gnt0_nxt;
            r_gnt1       <= w_gnt1_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_busy       <= w_busy_nxt;
            r_mem_ce     <= w_ce_nxt;
            r_mem_r      <= w_r_nxt;
            r_mem_oe     <= w_oe_nxt;
            r_mem_w      <= w_w_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_rdata      <= w_rdata_nxt;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign busy      = r_busy;
    assign mem_ce    = r_mem_ce;
    assign mem_r     = r_mem_r;
    assign mem_oe    = r_mem_oe;
    assign mem_w     = r_mem_w;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed vector bench for mem_bus_arbiter. One instance uses
//               round-robin arbitration, a second uses fixed priority; both
//               share the requester inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;

    logic        rr_gnt0, rr_gnt1, rr_ack0, rr_ack1, rr_busy;
    logic        rr_ce, rr_r, rr_oe, rr_w;
    logic [15:0] rr_maddr;
    logic [7:0]  rr_mwdata, rr_mrdata, rr_rdata;

    logic        fx_gnt0, fx_gnt1, fx_ack0, fx_ack1, fx_busy;
    logic        fx_ce, fx_r, fx_oe, fx_w;
    logic [15:0] fx_maddr;
    logic [7:0]  fx_mwdata, fx_mrdata, fx_rdata;

    logic [8:0]  rr_ctl, fx_ctl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory contents: one marker location, the rest a simple address hash
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ 8'hC3;
    endfunction

    assign rr_mrdata = mem_model(rr_maddr);
    assign fx_mrdata = mem_model(fx_maddr);
    assign rr_ctl = {rr_gnt0, rr_gnt1, rr_ack0, rr_ack1, rr_busy, rr_ce, rr_r, rr_oe, rr_w};
    assign fx_ctl = {fx_gnt0, fx_gnt1, fx_ack0, fx_ack1, fx_busy, fx_ce, fx_r, fx_oe, fx_w};

    mem_bus_arbiter #(.PRIO_FIXED(0), .ADDR_W(16), .DATA_W(8)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(rr_gnt0), .gnt1(rr_gnt1), .ack0(rr_ack0), .ack1(rr_ack1),
        .rdata(rr_rdata), .busy(rr_busy),
        .mem_addr(rr_maddr), .mem_wdata(rr_mwdata), .mem_rdata(rr_mrdata),
        .mem_ce(rr_ce), .mem_r(rr_r), .mem_oe(rr_oe), .mem_w(rr_w)
    );

    mem_bus_arbiter #(.PRIO_FIXED(1), .ADDR_W(16), .DATA_W(8)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(fx_gnt0), .gnt1(fx_gnt1), .ack0(fx_ack0), .ack1(fx_ack1),
        .rdata(fx_rdata), .busy(fx_busy),
        .mem_addr(fx_maddr), .mem_wdata(fx_mwdata), .mem_rdata(fx_mrdata),
        .mem_ce(fx_ce), .mem_r(fx_r), .mem_oe(fx_oe), .mem_w(fx_w)
    );

    // ctl = {gnt0, gnt1, ack0, ack1, busy, ce, r, oe, w}
    typedef struct {
        logic        rn;
        logic        r0, w0, l0;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic        r1, w1, l1;
        logic [15:0] a1;
        logic [7:0]  d1;
        logic [8:0]  ctl;
        logic [15:0] maddr;
        logic [7:0]  mwd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rn,
                       input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [7:0] d1,
                       input logic [8:0] ctl, input logic [15:0] maddr,
                       input logic [7:0] mwd, input logic [7:0] rd);
        vec_t v;
        v.rn = rn; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.ctl = ctl; v.maddr = maddr; v.mwd = mwd; v.rd = rd;
        vq.push_back(v);
    endtask

    task automatic chk(input string name,
                       input logic [8:0] act_ctl, input logic [15:0] act_addr,
                       input logic [7:0] act_wd, input logic [7:0] act_rd,
                       input logic [8:0] exp_ctl, input logic [15:0] exp_addr,
                       input logic [7:0] exp_wd, input logic [7:0] exp_rd);
        n_vec++;
        if ({act_ctl, act_addr, act_wd, act_rd} !== {exp_ctl, exp_addr, exp_wd, exp_rd}) begin
            n_err++;
            $display("FAIL %s: got ctl=%b addr=%h wdata=%h rdata=%h, expected ctl=%b addr=%h wdata=%h rdata=%h",
                     name, act_ctl, act_addr, act_wd, act_rd, exp_ctl, exp_addr, exp_wd, exp_rd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        //   rn r0 w0 l0 addr0     d0     r1 w1 l1 addr1     d1     ctl            maddr     mwd    rd
        // reset
        add(0, 0,0,0, 16'h0000, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h0000, 8'h00, 8'h00);
        // single read by requester 0
        add(1, 1,0,0, 16'h1234, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b10_00_1_1100, 16'h1234, 8'h00, 8'h00);
        add(1, 1,0,0, 16'h1234, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b10_00_1_1010, 16'h1234, 8'h00, 8'h00);
        add(1, 1,0,0, 16'h1234, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b10_10_1_0000, 16'h1234, 8'h00, 8'hA5);
        add(1, 0,0,0, 16'h0000, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h1234, 8'h00, 8'hA5);
        // single write by requester 1
        add(1, 0,0,0, 16'h0000, 8'h00, 1,1,0, 16'h00FF, 8'h3C, 9'b01_00_1_1001, 16'h00FF, 8'h3C, 8'hA5);
        add(1, 0,0,0, 16'h0000, 8'h00, 1,1,0, 16'h00FF, 8'h3C, 9'b01_01_1_0000, 16'h00FF, 8'h3C, 8'hA5);
        add(1, 0,0,0, 16'h0000, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h00FF, 8'h3C, 8'hA5);
        // both read continuously: grants alternate 0,1,0 without IDLE gaps
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b10_00_1_1100, 16'h0010, 8'h00, 8'hA5);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b10_00_1_1010, 16'h0010, 8'h00, 8'hA5);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b10_10_1_0000, 16'h0010, 8'h00, 8'hD3);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b01_00_1_1100, 16'h0020, 8'h00, 8'hD3);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b01_00_1_1010, 16'h0020, 8'h00, 8'hD3);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b01_01_1_0000, 16'h0020, 8'h00, 8'hE3);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b10_00_1_1100, 16'h0010, 8'h00, 8'hE3);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b10_00_1_1010, 16'h0010, 8'h00, 8'hE3);
        add(1, 1,0,0, 16'h0010, 8'h00, 1,0,0, 16'h0020, 8'h00, 9'b10_10_1_0000, 16'h0010, 8'h00, 8'hD3);
        add(1, 0,0,0, 16'h0000, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h0010, 8'h00, 8'hD3);
        // lock burst: three reads by requester 0 while requester 1 waits
        add(1, 1,0,1, 16'h0040, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b10_00_1_1100, 16'h0040, 8'h00, 8'hD3);
        add(1, 1,0,1, 16'h0040, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_00_1_1010, 16'h0040, 8'h00, 8'hD3);
        add(1, 1,0,1, 16'h0040, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_10_1_0000, 16'h0040, 8'h00, 8'h83);
        add(1, 1,0,1, 16'h0041, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_00_1_1100, 16'h0041, 8'h00, 8'h83);
        add(1, 1,0,1, 16'h0041, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_00_1_1010, 16'h0041, 8'h00, 8'h83);
        add(1, 1,0,1, 16'h0041, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_10_1_0000, 16'h0041, 8'h00, 8'h82);
        add(1, 1,0,1, 16'h0042, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_00_1_1100, 16'h0042, 8'h00, 8'h82);
        add(1, 1,0,1, 16'h0042, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_00_1_1010, 16'h0042, 8'h00, 8'h82);
        add(1, 1,0,1, 16'h0042, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b10_10_1_0000, 16'h0042, 8'h00, 8'h81);
        add(1, 1,0,0, 16'h0042, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b01_00_1_1100, 16'h0050, 8'h00, 8'h81);
        add(1, 0,0,0, 16'h0000, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b01_00_1_1010, 16'h0050, 8'h00, 8'h81);
        add(1, 0,0,0, 16'h0000, 8'h00, 1,0,0, 16'h0050, 8'h00, 9'b01_01_1_0000, 16'h0050, 8'h00, 8'h93);
        add(1, 0,0,0, 16'h0000, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h0050, 8'h00, 8'h93);
        // reset during RD_D abandons the read; a new requester-1 read completes
        add(1, 1,0,0, 16'h0077, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b10_00_1_1100, 16'h0077, 8'h00, 8'h93);
        add(1, 1,0,0, 16'h0077, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b10_00_1_1010, 16'h0077, 8'h00, 8'h93);
        add(0, 1,0,0, 16'h0077, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h0000, 8'h00, 8'h00);
        add(1, 0,0,0, 16'h0000, 8'h00, 1,0,0, 16'h0099, 8'h00, 9'b01_00_1_1100, 16'h0099, 8'h00, 8'h00);
        add(1, 0,0,0, 16'h0000, 8'h00, 1,0,0, 16'h0099, 8'h00, 9'b01_00_1_1010, 16'h0099, 8'h00, 8'h00);
        add(1, 0,0,0, 16'h0000, 8'h00, 1,0,0, 16'h0099, 8'h00, 9'b01_01_1_0000, 16'h0099, 8'h00, 8'h5A);
        add(1, 0,0,0, 16'h0000, 8'h00, 0,0,0, 16'h0000, 8'h00, 9'b00_00_0_0000, 16'h0099, 8'h00, 8'h5A);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n = vq[i].rn;
            req0 = vq[i].r0; we0 = vq[i].w0; lock0 = vq[i].l0; addr0 = vq[i].a0; wdata0 = vq[i].d0;
            req1 = vq[i].r1; we1 = vq[i].w1; lock1 = vq[i].l1; addr1 = vq[i].a1; wdata1 = vq[i].d1;
            step();
            chk($sformatf("vec%0d", i), rr_ctl, rr_maddr, rr_mwdata, rr_rdata,
                vq[i].ctl, vq[i].maddr, vq[i].mwd, vq[i].rd);
        end

        // Requester 0 writes alone so that last_grant becomes 0 in both instances
        req0 = 1'b1; we0 = 1'b1; lock0 = 1'b0; addr0 = 16'h0100; wdata0 = 8'h11;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 8'h00;
        step();
        chk("fx_wr_solo", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b10_00_1_1001, 16'h0100, 8'h11, 8'h5A);
        step();
        chk("fx_wr_solo_ack", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b10_10_1_0000, 16'h0100, 8'h11, 8'h5A);
        req0 = 1'b0;
        step();
        chk("rr_idle_after_wr", rr_ctl, rr_maddr, rr_mwdata, rr_rdata, 9'b00_00_0_0000, 16'h0100, 8'h11, 8'h5A);

        // Conflict with last_grant=0: round-robin picks 1, fixed priority picks 0
        req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 16'h0101; wdata0 = 8'h12;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 8'h22;
        step();
        chk("rr_conflict_gnt1", rr_ctl, rr_maddr, rr_mwdata, rr_rdata, 9'b01_00_1_1001, 16'h0200, 8'h22, 8'h5A);
        chk("fx_conflict_gnt0", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b10_00_1_1001, 16'h0101, 8'h12, 8'h5A);
        step();
        chk("rr_conflict_ack1", rr_ctl, rr_maddr, rr_mwdata, rr_rdata, 9'b01_01_1_0000, 16'h0200, 8'h22, 8'h5A);
        chk("fx_burst_ack0", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b10_10_1_0000, 16'h0101, 8'h12, 8'h5A);

        // Fixed priority: requester 0 keeps writing every 2 cycles, requester 1 waits
        for (int k = 0; k < 2; k++) begin
            addr0 = 16'h0102 + 16'(k);
            wdata0 = 8'h13 + 8'(k);
            step();
            chk($sformatf("fx_burst_wr%0d", k), fx_ctl, fx_maddr, fx_mwdata, fx_rdata,
                9'b10_00_1_1001, 16'h0102 + 16'(k), 8'h13 + 8'(k), 8'h5A);
            step();
            chk($sformatf("fx_burst_ack%0d", k), fx_ctl, fx_maddr, fx_mwdata, fx_rdata,
                9'b10_10_1_0000, 16'h0102 + 16'(k), 8'h13 + 8'(k), 8'h5A);
        end

        // Requester 0 drops: requester 1 gets the bus straight from the ACK cycle
        req0 = 1'b0; lock0 = 1'b0;
        step();
        chk("fx_handover_wr1", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b01_00_1_1001, 16'h0200, 8'h22, 8'h5A);
        step();
        chk("fx_handover_ack1", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b01_01_1_0000, 16'h0200, 8'h22, 8'h5A);
        req1 = 1'b0;
        step();
        chk("fx_final_idle", fx_ctl, fx_maddr, fx_mwdata, fx_rdata, 9'b00_00_0_0000, 16'h0200, 8'h22, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
